imem_loadable: RTL and testbench

Parametrised, loadable instruction memory with a handshaked fetch port, sitting between the fetch stage and the decode stage of the pipelined RV32I core. Next generation of the single-port synchronous instruction ROM:
- Depth and width are generic.
- A program-load port writes words before or between runs.
- Fetch supports stall, flush and fault reporting for misaligned or out-of-range PCs.
- Optional random-program initialisation is kept for simulation.

---
 rtl/imem_loadable.sv | 156 +++++++++++++++
 tb/tb_imem_loadable.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Loadable instruction memory with a 1-cycle registered fetch port, a stall/flush path and a program-load port.
// Latency: fetch result 1 cycle after accept; throughput 1/cycle. Backpressure: fetch_ready drops on stall or in LOAD.
// IMEM_RANDOM_INIT_EN (simulation only): fill memory with random legal RV32I words at time 0 instead of NOPs.
module imem_loadable #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [31:0]       fetch_pc_q,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t state, state_nxt;
  logic   mem_we;
  logic   accept;
  logic   pc_fault;
  logic [ADDR_W-1:0] fetch_idx;

`ifdef IMEM_RANDOM_INIT_EN
  logic [DATA_W-1:0] mem [DEPTH];

  // Random word from one of R, I-imm, LW, SW, B, JAL with word-aligned immediates.
  function automatic logic [31:0] rand_rv32i();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic [12:0] imm13;
    logic [20:0] imm21;
    rd    = 5'($urandom);
    rs1   = 5'($urandom);
    rs2   = 5'($urandom);
    f3    = 3'($urandom);
    imm12 = 12'($urandom) & 12'hFFC;
    imm13 = 13'($urandom) & 13'h1FFC;
    imm21 = 21'($urandom) & 21'h1FFFFC;
    case ($urandom_range(0, 5))
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      1: begin
        if (f3 == 3'd1)
          imm12 = {7'h00, rs2[4:2], 2'b00};
        else if (f3 == 3'd5)
          imm12 = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2[4:2], 2'b00};
        return {imm12, rs1, f3, rd, 7'h13};
      end
      2: return {imm12, rs1, 3'b010, rd, 7'h03};
      3: return {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], 7'h23};
      4: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;
        return {imm13[12], imm13[10:5], rs2, rs1, f3, imm13[4:1], imm13[11], 7'h63};
      end
      default: return {imm21[20], imm21[10:1], imm21[11], imm21[19:12], rd, 7'h6F};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'(rand_rv32i());
      $display("IMEM[%0d] = %h", i, mem[i]);
    end
  end
`else
  // Power-up image only; contents are deliberately outside the reset domain.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_INSTR};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_busy   = 1'b0;
    fetch_ready = 1'b0;
    mem_we      = 1'b0;
    case (state)
      ST_RUN: begin
        fetch_ready = !stall;
        if (load_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_busy = 1'b1;
        mem_we    = load_we;
        // A fresh load_start restarts the load even if load_done arrives with it.
        if (load_start)
          state_nxt = ST_LOAD;
        else if (load_done)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      load_count <= '0;
    else if (load_start)
      load_count <= '0;
    else if (mem_we && load_count != CNT_MAX)
      load_count <= load_count + 1'b1;
  end

  assign accept    = fetch_req && fetch_ready;
  assign pc_fault  = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:ADDR_W+2] != '0);
  assign fetch_idx = fetch_pc[ADDR_W+1:2];

  // A new accept wins over flush: flush only kills the result already held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= NOP_INSTR;
      fetch_pc_q  <= '0;
      fetch_fault <= 1'b0;
    end else if (accept) begin
      fetch_valid <= 1'b1;
      fetch_pc_q  <= fetch_pc;
      fetch_fault <= pc_fault;
      fetch_instr <= pc_fault ? NOP_INSTR : mem[fetch_idx];
    end else if (flush || !stall) begin
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised self-checking bench for imem_loadable against an array-based reference of memory and fetch outputs.
module tb_imem_loadable;

  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              fetch_req = 1'b0;
  logic [31:0]       fetch_pc = '0;
  logic              fetch_ready;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic [31:0]       fetch_pc_q;
  logic              fetch_fault;
  logic              load_start = 1'b0;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_done = 1'b0;
  logic              load_busy;
  logic [ADDR_W:0]   load_count;

  imem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .stall(stall), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc_q(fetch_pc_q), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_busy(load_busy), .load_count(load_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: memory image, which words are known, expected fetch outputs and word count.
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  bit          exp_valid;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  bit          exp_fault;
  bit          exp_known;
  int          exp_count;

  function automatic bit is_fault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc >= 32'(DEPTH * 4));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_instr = NOP; exp_pc = '0; exp_fault = 0; exp_known = 1; exp_count = 0;
  endtask

  task automatic model_fetch(input logic [31:0] pc);
    exp_valid = 1;
    exp_pc    = pc;
    exp_fault = is_fault(pc);
    exp_known = exp_fault ? 1'b1 : known[pc / 4];
    exp_instr = exp_fault ? NOP : model_mem[pc / 4];
  endtask

  task automatic load_word(input int addr, input logic [31:0] data, input bit done);
    load_we = 1; load_addr = ADDR_W'(addr); load_data = data; load_done = done;
    step();
    load_we = 0; load_done = 0;
    model_mem[addr] = data;
    known[addr] = 1;
    if (exp_count < DEPTH) exp_count++;
  endtask

  task automatic begin_load();
    load_start = 1;
    step();
    load_start = 0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== NOP || fetch_pc_q !== 32'h0 || fetch_fault !== 1'b0)
      $display("FAIL reset_fetch: valid=%b instr=%h pc_q=%h fault=%b, want 0/%h/0/0",
               fetch_valid, fetch_instr, fetch_pc_q, fetch_fault, NOP);
    else n_pass++;
    n_checks++;
    if (load_busy !== 1'b0 || load_count !== '0 || fetch_ready !== 1'b1)
      $display("FAIL reset_load: busy=%b count=%0d ready=%b, want 0/0/1", load_busy, load_count, fetch_ready);
    else n_pass++;
    model_reset();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_load_and_fetch();
    logic [31:0] prog [4];
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
    begin_load();
    n_checks++;
    if (load_busy !== 1'b1 || load_count !== '0 || fetch_ready !== 1'b0)
      $display("FAIL load_enter: busy=%b count=%0d ready=%b, want 1/0/0", load_busy, load_count, fetch_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) load_word(k, prog[k], 1'b0);
    load_done = 1;
    step();
    load_done = 0;
    n_checks++;
    if (load_busy !== 1'b0 || load_count !== 11'd4)
      $display("FAIL load_exit: busy=%b count=%0d, want 0/4", load_busy, load_count);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      fetch_req = 1; fetch_pc = 32'(4 * k);
      step();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_instr !== prog[k] || fetch_pc_q !== 32'(4 * k) || fetch_fault !== 1'b0)
        $display("FAIL b2b_fetch[%0d]: valid=%b instr=%h pc_q=%h fault=%b, want 1/%h/%h/0",
                 k, fetch_valid, fetch_instr, fetch_pc_q, fetch_fault, prog[k], 4 * k);
      else n_pass++;
    end
    fetch_req = 0;
    step();
    n_checks++;
    if (fetch_valid !== 1'b0) $display("FAIL b2b_idle: valid=%b, want 0", fetch_valid);
    else n_pass++;
  endtask

  task automatic test_fault();
    logic [31:0] pcs [2];
    pcs[0] = 32'h6; pcs[1] = 32'h1000;
    for (int k = 0; k < 2; k++) begin
      fetch_req = 1; fetch_pc = pcs[k];
      step();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_instr !== NOP || fetch_pc_q !== pcs[k])
        $display("FAIL fault_pc_%h: valid=%b fault=%b instr=%h pc_q=%h, want 1/1/%h/%h",
                 pcs[k], fetch_valid, fetch_fault, fetch_instr, fetch_pc_q, NOP, pcs[k]);
      else n_pass++;
    end
    fetch_req = 0;
    step();
  endtask

  task automatic test_stall();
    fetch_req = 1; fetch_pc = 32'h8;
    step();
    stall = 1; fetch_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0) $display("FAIL stall_ready[%0d]: ready=%b, want 0", k, fetch_ready);
      else n_pass++;
      step();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_instr !== 32'h002081B3 || fetch_pc_q !== 32'h8)
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc_q=%h, want 1/002081b3/00000008",
                 k, fetch_valid, fetch_instr, fetch_pc_q);
      else n_pass++;
    end
    stall = 0; fetch_req = 0;
    step();
  endtask

  task automatic test_flush();
    fetch_req = 1; fetch_pc = 32'h0;
    step();
    fetch_req = 0; flush = 1; stall = 1;
    step();
    n_checks++;
    if (fetch_valid !== 1'b0) $display("FAIL flush_over_stall: valid=%b, want 0", fetch_valid);
    else n_pass++;
    stall = 0; fetch_req = 1; fetch_pc = 32'h4;
    step();
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00A00113 || fetch_pc_q !== 32'h4)
      $display("FAIL flush_with_req: valid=%b instr=%h pc_q=%h, want 1/00a00113/00000004",
               fetch_valid, fetch_instr, fetch_pc_q);
    else n_pass++;
    flush = 0; fetch_req = 0;
    step();
  endtask

  task automatic test_run_we_ignored();
    int cnt_before;
    cnt_before = exp_count;
    load_we = 1; load_addr = 10'd2; load_data = 32'hFFFF_FFFF;
    step();
    load_we = 0;
    n_checks++;
    if (load_count !== 11'(cnt_before) || load_busy !== 1'b0)
      $display("FAIL run_we_count: count=%0d busy=%b, want %0d/0", load_count, load_busy, cnt_before);
    else n_pass++;
    fetch_req = 1; fetch_pc = 32'h8;
    step();
    fetch_req = 0;
    n_checks++;
    if (fetch_instr !== 32'h002081B3)
      $display("FAIL run_we_mem: instr=%h, want 002081b3", fetch_instr);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w0, w7;
    w0 = $urandom; w7 = $urandom;
    begin_load();
    load_word(0, w0, 1'b0);
    load_word(7, w7, 1'b0);
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (load_busy !== 1'b0 || load_count !== '0 || fetch_valid !== 1'b0)
      $display("FAIL reset_mid_load: busy=%b count=%0d valid=%b, want 0/0/0", load_busy, load_count, fetch_valid);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    step();
    n_checks++;
    if (fetch_ready !== 1'b1) $display("FAIL reset_state_run: ready=%b, want 1", fetch_ready);
    else n_pass++;
    fetch_req = 1; fetch_pc = 32'h0;
    step();
    n_checks++;
    if (fetch_instr !== w0) $display("FAIL retained_w0: instr=%h, want %h", fetch_instr, w0);
    else n_pass++;
    fetch_pc = 32'd28;
    step();
    n_checks++;
    if (fetch_instr !== w7) $display("FAIL retained_w7: instr=%h, want %h", fetch_instr, w7);
    else n_pass++;
    fetch_req = 0;
    step();
    exp_valid = 0;
  endtask

  task automatic test_saturate();
    begin_load();
    for (int k = 0; k < DEPTH + 6; k++) load_word(DEPTH - 1, $urandom, 1'b0);
    n_checks++;
    if (load_count !== 11'(exp_count) || exp_count != DEPTH)
      $display("FAIL count_saturate: count=%0d, want %0d", load_count, DEPTH);
    else n_pass++;
    load_start = 1; load_done = 1;
    step();
    load_start = 0; load_done = 0;
    exp_count = 0;
    n_checks++;
    if (load_busy !== 1'b1 || load_count !== '0)
      $display("FAIL start_beats_done: busy=%b count=%0d, want 1/0", load_busy, load_count);
    else n_pass++;
    load_done = 1;
    step();
    load_done = 0;
  endtask

  task automatic test_random();
    int n;
    int r;
    begin_load();
    n = $urandom_range(5, 20);
    for (int k = 0; k < n; k++) load_word($urandom_range(0, 31), $urandom, k == n - 1);
    n_checks++;
    if (load_busy !== 1'b0 || load_count !== 11'(exp_count))
      $display("FAIL rand_load: busy=%b count=%0d, want 0/%0d", load_busy, load_count, exp_count);
    else n_pass++;
    exp_valid = 0;
    for (int c = 0; c < 300; c++) begin
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      fetch_req = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r < 7) fetch_pc = 32'($urandom_range(0, 40)) * 4;
      else if (r == 7) fetch_pc = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
      else fetch_pc = $urandom | 32'h1000;
      #1;
      n_checks++;
      if (fetch_ready !== !stall) $display("FAIL rand_ready[%0d]: ready=%b stall=%b", c, fetch_ready, stall);
      else n_pass++;
      if (fetch_req && !stall) model_fetch(fetch_pc);
      else if (flush || !stall) exp_valid = 0;
      step();
      n_checks++;
      if (fetch_valid !== exp_valid)
        $display("FAIL rand_valid[%0d]: valid=%b, want %b", c, fetch_valid, exp_valid);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (fetch_pc_q !== exp_pc || fetch_fault !== exp_fault || (exp_known && fetch_instr !== exp_instr))
          $display("FAIL rand_data[%0d]: pc_q=%h fault=%b instr=%h, want %h/%b/%h",
                   c, fetch_pc_q, fetch_fault, fetch_instr, exp_pc, exp_fault, exp_instr);
        else n_pass++;
      end
    end
    stall = 0; flush = 0; fetch_req = 0;
    step();
  endtask

  task automatic test_unloaded();
    logic [6:0] op;
    fetch_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fetch_pc = 32'(i) * 4;
      step();
      op = fetch_instr[6:0];
      n_checks++;
      if (known[i]) begin
        if (fetch_instr !== model_mem[i])
          $display("FAIL image[%0d]: instr=%h, want %h", i, fetch_instr, model_mem[i]);
        else n_pass++;
      end else begin
        if (!(op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h6F))
          $display("FAIL image_opcode[%0d]: instr=%h has illegal opcode", i, fetch_instr);
        else n_pass++;
      end
    end
    fetch_req = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = NOP;
`ifdef IMEM_RANDOM_INIT_EN
      known[i] = 0;
`else
      known[i] = 1;
`endif
    end
    model_reset();
    test_reset();
    test_load_and_fetch();
    test_fault();
    test_stall();
    test_flush();
    test_run_we_ignored();
    test_reset_mid_load();
    test_saturate();
    test_random();
    test_unloaded();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
